// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Receive-side controller between the UART receiver datapath and the
// peripheral register interface. Completed bytes are stored in a
// first-word-fall-through FIFO. The block tracks overrun, raises a level
// watermark interrupt, and raises a character-timeout interrupt after
// TIMEOUT_BITS idle bit-times while data is waiting.
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous reset, active-high
//   en_i            receive enable (blocks pushes, idles the timeout FSM)
//   clr_i           synchronous flush of FIFO, overrun and timeout
//   clks_per_bit_i  clocks per UART bit (0 is treated as 1)
//   rx_dv_i         single-cycle byte-valid strobe from the receiver
//   rx_byte_i       received byte, qualified by rx_dv_i
//   rx_sbit_i       start-bit-detected pulse from the receiver
//   rd_i            pop request (ignored while empty)
//   watermark_i     interrupt threshold, 0 disables
//   rd_data_o       FIFO head, valid when rd_valid_o=1 (0 when empty)
//   rd_valid_o      FIFO non-empty
//   level_o         number of stored bytes, 0..DEPTH
//   overrun_o       sticky: a byte was dropped because the FIFO was full
//   irq_wm_o        level_o >= watermark_i and watermark_i != 0
//   irq_timeout_o   character timeout
module uart_rx_ctrl #(
    parameter int DEPTH        = 8,
    parameter int TIMEOUT_BITS = 40,
    parameter int LW           = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [15:0]   clks_per_bit_i,
    input  logic          rx_dv_i,
    input  logic [7:0]    rx_byte_i,
    input  logic          rx_sbit_i,
    input  logic          rd_i,
    input  logic [LW-1:0] watermark_i,
    output logic [7:0]    rd_data_o,
    output logic          rd_valid_o,
    output logic [LW-1:0] level_o,
    output logic          overrun_o,
    output logic          irq_wm_o,
    output logic          irq_timeout_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [BW-1:0] LAST_BIT   = BW'(TIMEOUT_BITS - 1);

    typedef enum logic [1:0] {
        T_IDLE,
        T_COUNT,
        T_EXPIRED
    } tstate_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [LW-1:0] level_nxt;
    logic          overrun;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          drop;

    assign rd_valid_o = (level != '0);
    assign full       = (level == FULL_LEVEL);
    assign push       = rx_dv_i & en_i & ~clr_i;
    assign pop        = rd_i & rd_valid_o & ~clr_i;
    // A simultaneous pop frees the slot the write lands in, so a full FIFO
    // still accepts the byte.
    assign wr_en      = push & (~full | pop);
    assign drop       = push & full & ~pop;

    always_comb begin
        level_nxt = level;
        if (clr_i) begin
            level_nxt = '0;
        end else if (wr_en && !pop) begin
            level_nxt = level + LW'(1);
        end else if (!wr_en && pop) begin
            level_nxt = level - LW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else if (clr_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            if (drop)  overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= rx_byte_i;
    end

    assign rd_data_o = rd_valid_o ? mem[rd_ptr] : '0;
    assign level_o   = level;
    assign overrun_o = overrun;
    assign irq_wm_o  = (watermark_i != '0) && (level >= watermark_i);

    // ------------------------------------------------------------------
    // Character timeout
    // ------------------------------------------------------------------
    tstate_t       state;
    tstate_t       state_nxt;
    logic [15:0]   tick_cnt;
    logic [15:0]   tick_nxt;
    logic [15:0]   tick_max;
    logic [15:0]   tick_adv;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_nxt;
    logic [BW-1:0] bit_adv;
    logic          tick_wrap;
    logic          at_last;
    logic          restart;

    assign tick_max  = (clks_per_bit_i == 16'd0) ? 16'd0 : clks_per_bit_i - 16'd1;
    // >= so that lowering clks_per_bit_i mid-count wraps on the next cycle
    assign tick_wrap = (tick_cnt >= tick_max);
    assign tick_adv  = tick_wrap ? 16'd0 : tick_cnt + 16'd1;
    assign bit_adv   = tick_wrap ? bit_cnt + BW'(1) : bit_cnt;
    assign at_last   = (bit_cnt == LAST_BIT) && tick_wrap;
    assign restart   = rx_dv_i | rx_sbit_i | pop;

    always_comb begin
        state_nxt = state;
        tick_nxt  = '0;
        bit_nxt   = '0;
        case (state)
            T_IDLE: begin
                // The cycle that leaves T_IDLE is already the first counted
                // cycle, keeping the expiry exactly TIMEOUT_BITS bit-times
                // after the push that made the FIFO non-empty.
                if (en_i && rd_valid_o) begin
                    if (restart) begin
                        state_nxt = T_COUNT;
                    end else if (at_last) begin
                        state_nxt = T_EXPIRED;
                    end else begin
                        state_nxt = T_COUNT;
                        tick_nxt  = tick_adv;
                        bit_nxt   = bit_adv;
                    end
                end
            end
            T_COUNT: begin
                if (!en_i || !rd_valid_o) begin
                    state_nxt = T_IDLE;
                end else if (restart) begin
                    state_nxt = T_COUNT;
                end else if (at_last) begin
                    state_nxt = T_EXPIRED;
                end else begin
                    tick_nxt = tick_adv;
                    bit_nxt  = bit_adv;
                end
            end
            T_EXPIRED: begin
                if (!en_i) begin
                    state_nxt = T_IDLE;
                end else if (restart) begin
                    state_nxt = (level_nxt != '0) ? T_COUNT : T_IDLE;
                end
            end
            default: state_nxt = T_IDLE;
        endcase
        if (clr_i) begin
            state_nxt = T_IDLE;
            tick_nxt  = '0;
            bit_nxt   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= T_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
        end
    end

    assign irq_timeout_o = (state == T_EXPIRED);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl. A queue-based reference model
// tracks FIFO contents, overrun and the number of quiet cycles since the
// last timeout restart; every clocked step compares all outputs.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int TB    = 40;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic          clr;
    logic [15:0]   cpb;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          rx_sbit;
    logic          rd;
    logic [LW-1:0] wm;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [LW-1:0] level;
    logic          overrun;
    logic          irq_wm;
    logic          irq_to;

    uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT_BITS(TB)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_i           (en),
        .clr_i          (clr),
        .clks_per_bit_i (cpb),
        .rx_dv_i        (rx_dv),
        .rx_byte_i      (rx_byte),
        .rx_sbit_i      (rx_sbit),
        .rd_i           (rd),
        .watermark_i    (wm),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .level_o        (level),
        .overrun_o      (overrun),
        .irq_wm_o       (irq_wm),
        .irq_timeout_o  (irq_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model
    logic [7:0] mq[$];
    bit         m_ovr;
    int         m_quiet;
    bit         m_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr   = 1'b0;
        m_quiet = 0;
        m_exp   = 1'b0;
    endtask

    task automatic model_update(input bit dv, input logic [7:0] b, input bit sb,
                                input bit r, input bit c);
        int  lvl_pre;
        int  eff;
        bit  popv;
        bit  pushv;
        lvl_pre = mq.size();
        eff     = (cpb == 16'd0) ? 1 : int'(cpb);
        popv    = r && (lvl_pre != 0) && !c;
        pushv   = dv && en && !c;
        if (c) begin
            mq.delete();
            m_ovr = 1'b0;
        end else begin
            if (popv) void'(mq.pop_front());
            if (pushv) begin
                if (lvl_pre < DEPTH || popv) mq.push_back(b);
                else m_ovr = 1'b1;
            end
        end
        if (c || !en) begin
            m_quiet = 0;
            m_exp   = 1'b0;
        end else if (dv || sb || popv) begin
            m_quiet = 0;
            m_exp   = 1'b0;
        end else if (lvl_pre == 0) begin
            m_quiet = 0;
            m_exp   = 1'b0;
        end else if (!m_exp) begin
            m_quiet++;
            if (m_quiet >= TB * eff) m_exp = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [7:0] ehead;
        ehead = (mq.size() != 0) ? mq[0] : 8'h00;
        check("rd_valid", rd_valid, mq.size() != 0);
        check("rd_data", rd_data, ehead);
        check("level", level, mq.size());
        check("overrun", overrun, m_ovr);
        check("irq_wm", irq_wm, (wm != 0) && (mq.size() >= int'(wm)));
        check("irq_timeout", irq_to, m_exp);
    endtask

    task automatic step(input bit dv, input logic [7:0] b, input bit sb,
                        input bit r, input bit c);
        rx_dv   = dv;
        rx_byte = b;
        rx_sbit = sb;
        rd      = r;
        clr     = c;
        @(posedge clk);
        model_update(dv, b, sb, r, c);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        int rate;
        int rate2;
        logic [15:0] cpb_opts [5];
        cpb_opts[0] = 16'd1; cpb_opts[1] = 16'd2; cpb_opts[2] = 16'd3;
        cpb_opts[3] = 16'd0; cpb_opts[4] = 16'd5;

        rst = 1'b1; en = 1'b0; clr = 1'b0; cpb = 16'd4;
        rx_dv = 1'b0; rx_byte = 8'h00; rx_sbit = 1'b0; rd = 1'b0; wm = '0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        // basic FWFT ordering
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        check("first_head", rd_data, 8'hA5);
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
        check("level3", level, 3);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("head2", rd_data, 8'h3C);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("head3", rd_data, 8'h7E);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("empty_valid", rd_valid, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);   // pop while empty is ignored
        step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);   // empty push+pop: push only
        check("empty_pushpop", level, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // overrun and full push+pop
        for (int i = 0; i < 9; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check("full_level", level, 8);
        check("full_ovr", overrun, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("full_head", rd_data, i);
            step(1'b1, 8'(8'h10 + i), 1'b0, 1'b1, 1'b0);
            check("full_keep", level, 8);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ovr_sticky", overrun, 1'b1);

        // watermark
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        wm = LW'(4);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        check("wm_lvl3", irq_wm, 1'b0);
        step(1'b1, 8'h23, 1'b0, 1'b0, 1'b0);
        check("wm_lvl4", irq_wm, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h24 + i), 1'b0, 1'b0, 1'b0);
        wm = '0;
        idle();
        check("wm_zero", irq_wm, 1'b0);
        wm = LW'(9);
        idle();
        check("wm_above", irq_wm, 1'b0);
        wm = LW'(8);
        idle();
        check("wm_eq_depth", irq_wm, 1'b1);
        wm = '0;

        // timeout latency
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cpb = 16'd4;
        step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            idle();
            if (irq_to === 1'b1) begin n = i; break; end
        end
        check("to_latency", n, 160);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("to_clear_pop", irq_to, 1'b0);

        step(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 100; i++) idle();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("to_sbit_low", irq_to, 1'b0);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            idle();
            if (irq_to === 1'b1) begin n = i; break; end
        end
        check("to_sbit_latency", n, 160);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // flush while full with concurrent byte, then disabled reception
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        check("pre_flush_ovr", overrun, 1'b1);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        check("flush_level", level, 0);
        check("flush_ovr", overrun, 1'b0);
        en = 1'b0;
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        check("dis_level", level, 0);
        en = 1'b1;

        // reset mid-traffic
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 170; i++) idle();
        check("pre_rst_level", level, 3);
        check("pre_rst_ovr", overrun, 1'b1);
        check("pre_rst_to", irq_to, 1'b1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_level", level, 0);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_data", rd_data, 8'h00);
        check("rst_ovr", overrun, 1'b0);
        check("rst_to", irq_to, 1'b0);
        check("rst_wm", irq_wm, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic against the model
        for (int seg = 0; seg < 8; seg++) begin
            cpb = cpb_opts[$urandom_range(0, 4)];
            wm  = LW'($urandom_range(0, 9));
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            rate  = ($urandom_range(0, 1) == 0) ? 20 : 50;
            rate2 = ($urandom_range(0, 1) == 0) ? 0 : 2;
            for (int i = 0; i < 300; i++) begin
                int r;
                r = (i < 80) ? rate : rate2;
                if ($urandom_range(0, 99) == 0) en = ~en;
                if (i == 80) en = 1'b1;
                step($urandom_range(0, 99) < r, 8'($urandom),
                     (r != 0) && ($urandom_range(0, 99) == 0),
                     $urandom_range(0, 99) < r / 2,
                     $urandom_range(0, 299) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
